vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator, successor to the fixed 640x480 timing block. Produces hSync/vSync, pixel coordinates, an active-video qualifier, and line/frame start strobes for any mode set by porch, sync and polarity parameters. Sits between the pixel-rate enable generator and the sprite/playfield renderers. All timing is advanced by a pixel-enable on the system clock.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_SYNC_NEG, 1, 1 = hSync active-low, 0 = active-high
V_SYNC_NEG, 1, 1 = vSync active-low, 0 = active-high
POS_W, 10, width of hPos/vPos
FRAME_W, 8, width of frameCount

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
enable  in  1  pixel-rate enable; timing advances only on clk edges where enable=1
hSync  out  1  horizontal sync, polarity per H_SYNC_NEG
vSync  out  1  vertical sync, polarity per V_SYNC_NEG
hPos  out  POS_W  current pixel column, 0..H_TOTAL-1
vPos  out  POS_W  current line, 0..V_TOTAL-1
activeVideo  out  1  1 when hPos<H_ACTIVE and vPos<V_ACTIVE
lineStart  out  1  one-clk strobe when hPos becomes 0
frameStart  out  1  one-clk strobe when hPos and vPos both become 0
frameCount  out  FRAME_W  frame counter (see Optional Feature)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 525).
- Elaboration check: POS_W must represent max(H_TOTAL,V_TOTAL)-1; otherwise a generate-time error is forced.
- All outputs registered; hSync, vSync, activeVideo are decoded from the next counter values, so they align with hPos/vPos in the same cycle (zero skew).
- Reset (reset=1 at clk edge, overrides enable): hPos=H_TOTAL-1, vPos=V_TOTAL-1, hSync/vSync inactive level, activeVideo=0, lineStart=0, frameStart=0, frameCount=0. The first enable after reset therefore wraps to (0,0) and fires lineStart and frameStart.
- On enable=1: if hPos==H_TOTAL-1 then hPos<=0, lineStart<=1, and vPos<=(vPos==V_TOTAL-1)?0:vPos+1; else hPos<=hPos+1. frameStart<=1 when the wrap yields (0,0).
- On enable=0: counters, syncs, activeVideo hold; lineStart and frameStart forced to 0. Strobes last exactly one clk even if enable then drops.
- hSync active iff H_ACTIVE+H_FP <= hPos < H_ACTIVE+H_FP+H_SYNC (default 656..751).
- vSync active iff V_ACTIVE+V_FP <= vPos < V_ACTIVE+V_FP+V_SYNC (default 490..491), for the whole line, independent of hPos.
- Active level = 0 when *_SYNC_NEG=1, else 1; inactive is the complement.
- Continuous enable=1 is legal (one pixel per clk).
- Reset mid-frame: next cycle shows reset values; no partial strobe.

Optional Feature:
Macro VGA_FRAME_COUNT_EN. Defined: frameCount increments by 1 (mod 2^FRAME_W) in the same cycle frameStart is asserted; the first post-reset frameStart sets it to 1. Not defined: frameCount is tied to 0 and its register is not synthesised; all other behaviour is identical.

Test Plan:
- Defaults, reset held 3 clks, then enable=1 -> during reset hPos=799, vPos=524, hSync=vSync=1, activeVideo=0; first enable gives hPos=0, vPos=0, lineStart=frameStart=1, activeVideo=1.
- Free-run enable=1 one line -> hSync=0 exactly for hPos 656..751; activeVideo=0 from hPos 640; at 799->0 vPos goes 0->1, lineStart=1, frameStart=0.
- Free-run one full frame -> vSync=0 exactly for vPos 490..491 (1600 enables); vPos 524->0 with frameStart=1 once per 420000 enables; frameCount 1->2 with VGA_FRAME_COUNT_EN, 0 without.
- enable toggled 1-of-4 clks -> hPos advances once per 4 clks; lineStart width 1 clk; outputs hold while enable=0.
- reset asserted at hPos=300, vPos=200 together with enable=1 -> next cycle hPos=799, vPos=524, syncs inactive, frameCount=0.
- Override H_ACTIVE=8,H_FP=2,H_SYNC=2,H_BP=2,V_ACTIVE=4,V_FP=1,V_SYNC=1,V_BP=1,H_SYNC_NEG=0,V_SYNC_NEG=0,POS_W=4 -> hSync=1 only at hPos 10..11, vSync=1 only at vPos 5, wrap at hPos 13 and vPos 6.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: syncs, pixel coordinates, active-video and line/frame strobes.
// Optional frame counter enabled by defining VGA_FRAME_COUNT_EN; otherwise frameCount is tied to 0.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int H_SYNC_NEG = 1,
  parameter int V_SYNC_NEG = 1,
  parameter int POS_W      = 10,
  parameter int FRAME_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic               hSync,
  output logic               vSync,
  output logic [POS_W-1:0]   hPos,
  output logic [POS_W-1:0]   vPos,
  output logic               activeVideo,
  output logic               lineStart,
  output logic               frameStart,
  output logic [FRAME_W-1:0] frameCount
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

  localparam logic [POS_W-1:0] H_LAST = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] V_LAST = POS_W'(V_TOTAL - 1);
  localparam logic H_INACT = (H_SYNC_NEG != 0);
  localparam logic V_INACT = (V_SYNC_NEG != 0);

  if ((MAX_TOTAL - 1) >= (1 << POS_W)) begin : g_pos_w_too_small
    $error("vga_timing_gen: POS_W too narrow for H_TOTAL/V_TOTAL");
  end

  // Sync level for a coordinate; XOR with the polarity flag turns "active" into the pin level.
  function automatic logic sync_level(input logic [POS_W-1:0] pos, input int lo, input int hi,
                                      input logic neg);
    logic act;
    act = (int'(pos) >= lo) && (int'(pos) < hi);
    return act ^ neg;
  endfunction

  logic [POS_W-1:0] hpos_q, hpos_d;
  logic [POS_W-1:0] vpos_q, vpos_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             av_q, av_d;
  logic             ls_q, ls_d;
  logic             fs_q, fs_d;

  always_comb begin
    hpos_d = hpos_q;
    vpos_d = vpos_q;
    ls_d   = 1'b0;
    fs_d   = 1'b0;
    if (enable) begin
      if (hpos_q == H_LAST) begin
        hpos_d = '0;
        ls_d   = 1'b1;
        if (vpos_q == V_LAST) begin
          vpos_d = '0;
          fs_d   = 1'b1;
        end else begin
          vpos_d = vpos_q + 1'b1;
        end
      end else begin
        hpos_d = hpos_q + 1'b1;
      end
    end
    // Decoded from next counters so the registered outputs line up with hPos/vPos.
    hs_d = sync_level(hpos_d, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC, H_INACT);
    vs_d = sync_level(vpos_d, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC, V_INACT);
    av_d = (int'(hpos_d) < H_ACTIVE) && (int'(vpos_d) < V_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hpos_q <= H_LAST;
      vpos_q <= V_LAST;
      hs_q   <= H_INACT;
      vs_q   <= V_INACT;
      av_q   <= 1'b0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      av_q   <= av_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [FRAME_W-1:0] fc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fc_q <= '0;
    end else if (fs_d) begin
      fc_q <= fc_q + 1'b1;
    end
  end

  assign frameCount = fc_q;
`else
  assign frameCount = '0;
`endif

  assign hSync       = hs_q;
  assign vSync       = vs_q;
  assign hPos        = hpos_q;
  assign vPos        = vpos_q;
  assign activeVideo = av_q;
  assign lineStart   = ls_q;
  assign frameStart  = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a tiny override instance, both checked
// every cycle against a linear pixel-index model of the raster.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-mode DUT
  logic       rst_d, en_d;
  logic       hs_d, vs_d, av_d, ls_d, fs_d;
  logic [9:0] hp_d, vp_d;
  logic [7:0] fc_d;

  vga_timing_gen dut (
    .clk(clk), .reset(rst_d), .enable(en_d),
    .hSync(hs_d), .vSync(vs_d), .hPos(hp_d), .vPos(vp_d),
    .activeVideo(av_d), .lineStart(ls_d), .frameStart(fs_d), .frameCount(fc_d)
  );

  // Small override DUT, positive syncs
  logic       rst_s, en_s;
  logic       hs_s, vs_s, av_s, ls_s, fs_s;
  logic [3:0] hp_s, vp_s;
  logic [7:0] fc_s;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_NEG(0), .V_SYNC_NEG(0), .POS_W(4), .FRAME_W(8)
  ) dut_s (
    .clk(clk), .reset(rst_s), .enable(en_s),
    .hSync(hs_s), .vSync(vs_s), .hPos(hp_s), .vPos(vp_s),
    .activeVideo(av_s), .lineStart(ls_s), .frameStart(fs_s), .frameCount(fc_s)
  );

  logic [63:0] obs_d, obs_s, exp_d, exp_s;
  assign obs_d = {19'b0, hs_d, vs_d, 6'b0, hp_d, 6'b0, vp_d, av_d, ls_d, fs_d, fc_d};
  assign obs_s = {19'b0, hs_s, vs_s, 12'b0, hp_s, 12'b0, vp_s, av_s, ls_s, fs_s, fc_s};

  int total = 0;
  int passed = 0;

  // Model: each raster is a linear pixel index within the frame.
  int  pix_d, mfc_d, pix_s, mfc_s;
  bit  mls_d, mfs_d, mls_s, mfs_s;
  localparam int DH = 800, DT = 800 * 525;
  localparam int SH = 14,  ST = 14 * 7;

  function automatic logic [63:0] model_vec(int pix, int ha, int hfp, int hsw, int hbp,
                                            int va, int vfp, int vsw, bit hneg, bit vneg,
                                            bit ls, bit fs, int fc);
    int  ht, h, v;
    bit  hsa, vsa, av;
    ht  = ha + hfp + hsw + hbp;
    h   = pix % ht;
    v   = pix / ht;
    hsa = (h >= ha + hfp) && (h < ha + hfp + hsw);
    vsa = (v >= va + vfp) && (v < va + vfp + vsw);
    av  = (h < ha) && (v < va);
    return {19'b0, hsa ^ hneg, vsa ^ vneg, 16'(h), 16'(v), av, ls, fs, 8'(fc)};
  endfunction

  task automatic step(input bit rd, input bit ed, input bit rs, input bit es);
    rst_d = rd; en_d = ed; rst_s = rs; en_s = es;
    @(posedge clk);
    if (rd) begin
      pix_d = DT - 1; mls_d = 0; mfs_d = 0; mfc_d = 0;
    end else if (ed) begin
      pix_d = (pix_d + 1) % DT; mls_d = (pix_d % DH) == 0; mfs_d = (pix_d == 0);
`ifdef VGA_FRAME_COUNT_EN
      if (mfs_d) mfc_d = (mfc_d + 1) % 256;
`endif
    end else begin
      mls_d = 0; mfs_d = 0;
    end
    if (rs) begin
      pix_s = ST - 1; mls_s = 0; mfs_s = 0; mfc_s = 0;
    end else if (es) begin
      pix_s = (pix_s + 1) % ST; mls_s = (pix_s % SH) == 0; mfs_s = (pix_s == 0);
`ifdef VGA_FRAME_COUNT_EN
      if (mfs_s) mfc_s = (mfc_s + 1) % 256;
`endif
    end else begin
      mls_s = 0; mfs_s = 0;
    end
    exp_d = model_vec(pix_d, 640, 16, 96, 48, 480, 10, 2, 1, 1, mls_d, mfs_d, mfc_d);
    exp_s = model_vec(pix_s, 8, 2, 2, 2, 4, 1, 1, 0, 0, mls_s, mfs_s, mfc_s);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 1);
      total++;
      if (obs_d !== exp_d) $display("FAIL reset_def: got %h expected %h", obs_d, exp_d);
      else passed++;
      total++;
      if (obs_s !== exp_s) $display("FAIL reset_small: got %h expected %h", obs_s, exp_s);
      else passed++;
    end
    step(0, 1, 0, 1);
    total++;
    if (obs_d !== exp_d) $display("FAIL first_enable_def: got %h expected %h", obs_d, exp_d);
    else passed++;
    total++;
    if (obs_s !== exp_s) $display("FAIL first_enable_small: got %h expected %h", obs_s, exp_s);
    else passed++;
  endtask

  task automatic test_free_run_line();
    for (int i = 0; i < 1700; i++) begin
      step(0, 1, 0, 1);
      total++;
      if (obs_d !== exp_d) $display("FAIL line_def cyc %0d: got %h expected %h", i, obs_d, exp_d);
      else passed++;
      total++;
      if (obs_s !== exp_s) $display("FAIL line_small cyc %0d: got %h expected %h", i, obs_s, exp_s);
      else passed++;
    end
  endtask

  task automatic test_enable_1of4();
    for (int i = 0; i < 3400; i++) begin
      step(0, (i % 4) == 0, 0, (i % 4) == 0);
      total++;
      if (obs_d !== exp_d) $display("FAIL en1of4_def cyc %0d: got %h expected %h", i, obs_d, exp_d);
      else passed++;
      total++;
      if (obs_s !== exp_s) $display("FAIL en1of4_small cyc %0d: got %h expected %h", i, obs_s, exp_s);
      else passed++;
    end
  endtask

  task automatic test_random_enable();
    for (int i = 0; i < 4000; i++) begin
      step(0, $urandom_range(0, 1) == 1, 0, $urandom_range(0, 2) != 0);
      total++;
      if (obs_d !== exp_d) $display("FAIL rand_en_def cyc %0d: got %h expected %h", i, obs_d, exp_d);
      else passed++;
      total++;
      if (obs_s !== exp_s) $display("FAIL rand_en_small cyc %0d: got %h expected %h", i, obs_s, exp_s);
      else passed++;
    end
  endtask

  task automatic test_small_frames();
    for (int i = 0; i < 5 * ST; i++) begin
      step(0, 1, 0, 1);
      total++;
      if (obs_s !== exp_s) $display("FAIL frames_small cyc %0d: got %h expected %h", i, obs_s, exp_s);
      else passed++;
    end
  endtask

  task automatic test_reset_midframe();
    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(20, 1500);
      for (int i = 0; i < n; i++) step(0, 1, 0, 1);
      step(1, 1, 1, 1);
      total++;
      if (obs_d !== exp_d) $display("FAIL midreset_def k%0d: got %h expected %h", k, obs_d, exp_d);
      else passed++;
      total++;
      if (obs_s !== exp_s) $display("FAIL midreset_small k%0d: got %h expected %h", k, obs_s, exp_s);
      else passed++;
      for (int i = 0; i < 30; i++) begin
        step(0, $urandom_range(0, 1) == 1, 0, 1);
        total++;
        if (obs_d !== exp_d) $display("FAIL postreset_def k%0d c%0d: got %h expected %h", k, i, obs_d, exp_d);
        else passed++;
        total++;
        if (obs_s !== exp_s) $display("FAIL postreset_small k%0d c%0d: got %h expected %h", k, i, obs_s, exp_s);
        else passed++;
      end
    end
  endtask

  initial begin
    rst_d = 1; en_d = 0; rst_s = 1; en_s = 0;
    pix_d = DT - 1; pix_s = ST - 1; mfc_d = 0; mfc_s = 0;
    mls_d = 0; mfs_d = 0; mls_s = 0; mfs_s = 0;
    @(negedge clk);
    test_reset();
    test_free_run_line();
    test_enable_1of4();
    test_random_enable();
    test_small_frames();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
